// File: rtl/regfile_debug_access.sv
// Debug-side initiator for the integer register file: serialises read, write and dump
// commands onto the register-file ports after winning ownership through dbg_req/dbg_gnt.
module regfile_debug_access #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_addr,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            dbg_req,
  input  logic            dbg_gnt,
  output logic [4:0]      rf_a1,
  input  logic [XLEN-1:0] rf_rd1,
  output logic [4:0]      rf_a3,
  output logic            rf_we3,
  output logic [XLEN-1:0] rf_wd3
);

  localparam logic [1:0] OpRead    = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpDump    = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;
  localparam logic [4:0] LastIdx   = 5'(NREGS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StResp} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      idx_q;

  logic is_dump;
  logic is_write;
  logic dump_more;

  assign is_dump   = (op_q == OpDump);
  assign is_write  = (op_q == OpWrite);
  // A dump keeps the port ownership request up between beats until the last register.
  assign dump_more = is_dump && (idx_q != LastIdx);

  assign cmd_ready = rst_n && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpRead;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      dbg_req   <= 1'b0;
      rf_a1     <= '0;
      rf_a3     <= '0;
      rf_we3    <= 1'b0;
      rf_wd3    <= '0;
    end else begin
      // Write enable is a single-cycle pulse confined to ACCESS.
      rf_we3 <= 1'b0;

      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            idx_q   <= '0;
            if (cmd_op == OpIllegal) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_addr  <= cmd_addr;
              rsp_data  <= '0;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
              dbg_req   <= 1'b0;
            end else begin
              state_q <= StReq;
              dbg_req <= 1'b1;
            end
          end
        end

        StReq: begin
          if (dbg_gnt) begin
            state_q <= StAccess;
            if (is_write) begin
              rf_a3  <= addr_q;
              rf_wd3 <= wdata_q;
              rf_we3 <= (addr_q != 5'd0);
            end else begin
              rf_a1 <= is_dump ? idx_q : addr_q;
            end
          end
        end

        StAccess: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_last  <= !dump_more;
          rsp_addr  <= is_dump ? idx_q : addr_q;
          rsp_data  <= is_write ? wdata_q : rf_rd1;
          dbg_req   <= dump_more;
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (dump_more) begin
              idx_q   <= idx_q + 5'd1;
              dbg_req <= 1'b1;
              // Grant still held: skip REQ and go straight to the next beat's access.
              if (dbg_gnt) begin
                state_q <= StAccess;
                rf_a1   <= idx_q + 5'd1;
              end else begin
                state_q <= StReq;
              end
            end else begin
              state_q <= StIdle;
              dbg_req <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_access.sv
// Randomised self-checking bench for regfile_debug_access against an array model of
// the architectural register state.
module tb_regfile_debug_access;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_addr;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_last;
  logic            rsp_err;
  logic            dbg_req;
  logic            dbg_gnt;
  logic [4:0]      rf_a1;
  logic [XLEN-1:0] rf_rd1;
  logic [4:0]      rf_a3;
  logic            rf_we3;
  logic [XLEN-1:0] rf_wd3;

  logic [31:0] regs[32];      // the physical register file behind the port mux
  logic [31:0] ref_regs[32];  // expected architectural contents
  logic        load_en;

  int          total = 0;
  int          bad = 0;
  int          we_cnt = 0;
  int          req_cnt = 0;
  logic [4:0]  we_a3;
  logic [31:0] we_wd3;
  bit          gnt_rand = 1'b0;

  always #5 clk = ~clk;

  regfile_debug_access #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_addr (rsp_addr),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .rf_a1    (rf_a1),
    .rf_rd1   (rf_rd1),
    .rf_a3    (rf_a3),
    .rf_we3   (rf_we3),
    .rf_wd3   (rf_wd3)
  );

  // Without the grant the mux routes the core's port, seen here as garbage data.
  assign rf_rd1 = dbg_gnt ? regs[rf_a1] : 32'hbad0_bad0;

  always @(posedge clk) begin
    if (load_en) regs <= ref_regs;
    else if (dbg_gnt && rf_we3) regs[rf_a3] <= rf_wd3;
  end

  always @(negedge clk) begin
    if (rf_we3) begin
      we_cnt <= we_cnt + 1;
      we_a3  <= rf_a3;
      we_wd3 <= rf_wd3;
    end
    if (dbg_req) req_cnt <= req_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; optionally let the core take and return the grant,
  // never revoking it while an access could be in flight.
  task automatic tick();
    @(negedge clk);
    if (gnt_rand) begin
      if (dbg_gnt) begin
        if (rsp_valid || !dbg_req) dbg_gnt = ($urandom_range(3) != 0);
      end else begin
        dbg_gnt = ($urandom_range(2) == 0);
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input logic [4:0] ea, input logic [31:0] ed,
                          input logic el, input logic ee, input logic ereq, input int stall,
                          input bit drop);
    int n = 0;
    logic [39:0] snap;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq($sformatf("%s_valid", tag), 64'(rsp_valid), 64'd1);
    check_eq($sformatf("%s_req", tag), 64'(dbg_req), 64'(ereq));
    snap = {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err};
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq($sformatf("%s_stable", tag),
               64'({rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err}), 64'(snap));
    end
    check_eq($sformatf("%s_addr", tag), 64'(rsp_addr), 64'(ea));
    check_eq($sformatf("%s_data", tag), 64'(rsp_data), 64'(ed));
    check_eq($sformatf("%s_last", tag), 64'(rsp_last), 64'(el));
    check_eq($sformatf("%s_err", tag), 64'(rsp_err), 64'(ee));
    if (drop) dbg_gnt = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic run_dump(input string tag, input bit rand_stall);
    for (int k = 0; k < 32; k++) begin
      take_rsp($sformatf("%s%0d", tag, k), 5'(k), ref_regs[k], (k == 31), 1'b0, (k < 31),
               rand_stall ? int'($urandom_range(2)) : (k % 2), 1'b0);
    end
  endtask

  initial begin
    int w0;
    int r0;
    int n;
    logic [1:0]  op;
    logic [4:0]  a;
    logic [31:0] d;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 5'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b0;
    dbg_gnt   = 1'b1;
    load_en   = 1'b1;
    for (int i = 0; i < 32; i++) ref_regs[i] = $urandom;
    ref_regs[0] = 32'd0;
    ref_regs[5] = 32'h0000_0006;
    repeat (3) tick();
    load_en = 1'b0;

    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_dbg_req", 64'(dbg_req), 64'd0);
    check_eq("rst_we3", 64'(rf_we3), 64'd0);
    check_eq("rst_rsp_flags", 64'({rsp_last, rsp_err}), 64'd0);
    check_eq("rst_rsp_addr_data", 64'({rsp_addr, rsp_data}), 64'd0);
    check_eq("rst_rf_ports", 64'({rf_a1, rf_a3, rf_wd3}), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Read x5: request cycle, access cycle, then response.
    issue(2'b00, 5'd5, 32'd0);
    check_eq("rd_req_cycle", 64'(dbg_req), 64'd1);
    check_eq("rd_early_valid0", 64'(rsp_valid), 64'd0);
    tick();
    check_eq("rd_early_valid1", 64'(rsp_valid), 64'd0);
    tick();
    check_eq("rd_latency", 64'(rsp_valid), 64'd1);
    take_rsp("rd_x5", 5'd5, 32'h6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("rd_req_released", 64'(dbg_req), 64'd0);
    check_eq("rd_cmd_ready_back", 64'(cmd_ready), 64'd1);

    w0 = we_cnt;
    issue(2'b01, 5'd9, 32'hdead_beef);
    take_rsp("wr_x9", 5'd9, 32'hdead_beef, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    ref_regs[9] = 32'hdead_beef;
    check_eq("wr_x9_pulses", 64'(we_cnt - w0), 64'd1);
    check_eq("wr_x9_a3", 64'(we_a3), 64'd9);
    check_eq("wr_x9_wd3", 64'(we_wd3), 64'hdead_beef);
    issue(2'b00, 5'd9, 32'd0);
    take_rsp("rd_x9", 5'd9, 32'hdead_beef, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    w0 = we_cnt;
    issue(2'b01, 5'd0, 32'h1234_5678);
    take_rsp("wr_x0", 5'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("wr_x0_no_pulse", 64'(we_cnt - w0), 64'd0);
    issue(2'b00, 5'd0, 32'd0);
    take_rsp("rd_x0", 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    tick();
    w0 = we_cnt;
    r0 = req_cnt;
    issue(2'b11, 5'd7, 32'hffff_ffff);
    take_rsp("illegal", 5'd7, 32'd0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    tick();
    check_eq("illegal_no_req", 64'(req_cnt - r0), 64'd0);
    check_eq("illegal_no_we", 64'(we_cnt - w0), 64'd0);

    // Dump with alternating stalls and a grant outage after beat 10.
    issue(2'b10, 5'd17, 32'd0);
    for (int k = 0; k < 32; k++) begin
      take_rsp($sformatf("dump%0d", k), 5'(k), ref_regs[k], (k == 31), 1'b0, (k < 31), k % 2,
               (k == 10));
      if (k == 10) begin
        for (int c = 0; c < 3; c++) begin
          check_eq("gnt_low_no_rsp", 64'(rsp_valid), 64'd0);
          check_eq("gnt_low_req_held", 64'(dbg_req), 64'd1);
          tick();
        end
        dbg_gnt = 1'b1;
      end
    end

    // Reset in the middle of a dump response.
    issue(2'b10, 5'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      take_rsp($sformatf("pre_rst%0d", k), 5'(k), ref_regs[k], 1'b0, 1'b0, 1'b1, 0, 1'b0);
    end
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("mid_rst_beat5_addr", 64'(rsp_addr), 64'd5);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_req", 64'(dbg_req), 64'd0);
    check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("mid_rst_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("after_rst_valid", 64'(rsp_valid), 64'd0);
    issue(2'b00, 5'd5, 32'd0);
    take_rsp("rd_after_rst", 5'd5, ref_regs[5], 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Random command mix with a randomly withdrawn grant.
    gnt_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n  = int'($urandom_range(9));
      a  = 5'($urandom);
      d  = $urandom;
      op = (n < 4) ? 2'b00 : (n < 8) ? 2'b01 : (n == 8) ? 2'b11 : 2'b10;
      w0 = we_cnt;
      issue(op, a, d);
      case (op)
        2'b00: take_rsp("rnd_rd", a, ref_regs[a], 1'b1, 1'b0, 1'b0,
                        int'($urandom_range(2)), 1'b0);
        2'b01: begin
          take_rsp("rnd_wr", a, d, 1'b1, 1'b0, 1'b0, int'($urandom_range(2)), 1'b0);
          if (a != 5'd0) ref_regs[a] = d;
          check_eq("rnd_wr_pulses", 64'(we_cnt - w0), 64'(a != 5'd0));
        end
        2'b11: take_rsp("rnd_ill", a, 32'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        default: run_dump("rnd_dump", 1'b1);
      endcase
    end
    gnt_rand = 1'b0;
    dbg_gnt  = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_debug_access.md
# regfile_debug_access

Debug-side initiator for the 32×32 integer register file of the multicycle RV32I core. Accepts read, write and dump commands over a valid/ready command channel. Arbitrates for the register-file ports through a req/gnt pair with the core control unit, then drives the read port (a1→rd1) or write port (a3/we3/wd3) itself. Returns results over a valid/ready response channel. Sits between the debug transport and the port muxes in front of the register file.

## Interface
Parameters:
- XLEN, 32, data width of register-file entries
- NREGS, 32, number of architectural registers; dump walks x0..x(NREGS-1)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 read, 01 write, 10 dump, 11 illegal
- cmd_addr  in  5  target register (ignored for dump)
- cmd_wdata  in  XLEN  write data (write only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_addr  out  5  register the response refers to
- rsp_data  out  XLEN  read data, or echoed write data
- rsp_last  out  1  final beat of a command (always 1 except non-final dump beats)
- rsp_err  out  1  illegal op; rsp_data = 0
- dbg_req  out  1  request ownership of register-file ports
- dbg_gnt  in  1  ownership granted; the core mux selects this block's port signals
- rf_a1  out  5  read address to register file
- rf_rd1  in  XLEN  combinational read data from register file
- rf_a3  out  5  write address
- rf_we3  out  1  write enable
- rf_wd3  out  XLEN  write data

## Operation
- States: IDLE, REQ, ACCESS, RESP.
- IDLE: cmd_ready=1. On handshake, latch op/addr/wdata and clear the beat counter idx.
  - Ops 00/01/10 → REQ.
  - Op 11 → RESP with rsp_err=1, rsp_data=0, rsp_addr=cmd_addr, rsp_last=1. No dbg_req is raised.
- REQ: dbg_req=1. Go to ACCESS in the cycle after dbg_gnt is sampled 1. Wait indefinitely otherwise.
- ACCESS: exactly one cycle, dbg_req=1.
  - Read: rf_a1=addr; rf_rd1 is registered into rsp_data at the end of the cycle.
  - Dump: rf_a1=idx; rf_rd1 is registered into rsp_data at the end of the cycle.
  - Write: rf_a3=addr, rf_wd3=wdata, rf_we3=(addr!=0); rsp_data=wdata. A write to x0 is acknowledged but never pulses we3.
  - Then → RESP.
- RESP: rsp_valid=1. rsp_* outputs are held stable until the handshake.
  - dbg_req=1 only for a dump with idx<NREGS-1; otherwise dbg_req=0.
  - On handshake:
    - Non-dump, or dump with idx=NREGS-1: rsp_last=1 → IDLE.
    - Dump non-final: idx+1 → ACCESS if dbg_gnt=1 in the same cycle, else → REQ.
- idx is 5 bits, counts 0..NREGS-1, and never wraps within one dump.
- rf_we3 is 1 only in ACCESS for a write with addr≠0. It is 0 in every other cycle.
- The block never drives the register-file ports meaningfully unless in ACCESS. When idle, outputs hold their last values (we3=0).

## Timing
- Reset (rst_n=0 at posedge) forces IDLE, idx=0, and takes effect from any state, including mid-dump or mid-response. No response is pending after reset.
  - While rst_n is low: cmd_ready=0.
  - From the first cycle after rst_n deasserts: cmd_ready=1.
  - rsp_valid, rsp_last, rsp_err, dbg_req and rf_we3 = 0.
  - rsp_addr, rsp_data, rf_a1, rf_a3, rf_wd3 = 0.
- A write already clocked in ACCESS is not undone.
- Read/write latency with dbg_gnt held 1: handshake at edge T → REQ in cycle T+1 → ACCESS in cycle T+2 → rsp_valid in cycle T+3.
- Register-file write commits at the edge ending ACCESS. A subsequent read returns the new value.
- Dump with gnt=1 and rsp_ready=1: beat k valid in cycle T+3+2k; 32 beats total.
- Back-to-back commands: the next cmd_ready cycle is the cycle after the final response handshake. There is no overlap.
- dbg_gnt deasserting during REQ: stay in REQ.
- dbg_gnt is only sampled in REQ and at a dump RESP handshake. The core must not revoke gnt during ACCESS.

## Test plan
- Reset, then read x5 with register file preset x5=0x00000006 and gnt=1 → rsp_valid at T+3 with rsp_addr=5, rsp_data=0x6, rsp_last=1, rsp_err=0. dbg_req=0 after the handshake.
- Write x9=0xDEADBEEF, then read x9 → exactly one rf_we3 pulse with a3=9 and wd3=0xDEADBEEF. Write response echoes 0xDEADBEEF. Read returns 0xDEADBEEF.
- Write x0=0x12345678 → no rf_we3 pulse. Response rsp_addr=0, rsp_data=0x12345678. A following read of x0 returns 0.
- Dump with rsp_ready toggling 1/0 and dbg_gnt dropped for 3 cycles between beats 10 and 11:
  - 32 beats, rsp_addr 0..31 in order, data matching the register-file model.
  - rsp_last only on beat 31.
  - Outputs stable while stalled.
  - No ACCESS while gnt=0.
- Illegal op 11 with addr=7 → one response, rsp_err=1, rsp_data=0, rsp_last=1. dbg_req and rf_we3 never asserted.
- Assert rst_n=0 during dump beat 5 RESP → next cycle rsp_valid=0, dbg_req=0. One cycle after rst_n returns high, cmd_ready=1. A new read completes normally.
